// File: rtl/sm_proto_pkg.sv
// Shared protocol constants, state encoding and payload selection for sensor_responder.
package sm_proto_pkg;

  localparam logic [7:0] DEF_CHK_KEY = 8'h37;

  localparam logic [7:0] REQ_CH0     = 8'h01;
  localparam logic [7:0] REQ_CH1     = 8'h02;
  localparam logic [7:0] REQ_CH2     = 8'h03;
  localparam logic [7:0] REQ_CH3     = 8'h04;
  localparam logic [7:0] ALARM_CODE  = 8'h00;
  localparam logic [7:0] ERR_PAYLOAD = 8'hFF;
  localparam logic [7:0] ZERO_SUBST  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_P,
    ST_WAIT_P,
    ST_SEND_C,
    ST_WAIT_C,
    ST_GAP
  } state_t;

  // A channel reading of zero is substituted so that 8'h00 always means alarm.
  function automatic logic [7:0] request_payload(input logic [7:0]  code,
                                                 input logic [31:0] sensors);
    logic [7:0] result;
    result = ERR_PAYLOAD;
    case (code)
      REQ_CH0: result = sensors[7:0];
      REQ_CH1: result = sensors[15:8];
      REQ_CH2: result = sensors[23:16];
      REQ_CH3: result = sensors[31:24];
      default: result = ERR_PAYLOAD;
    endcase
    if (result == 8'h00) begin
      result = ZERO_SUBST;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte handshake with the UART transmitter: holds the byte, strobes it when the
// transmitter is free, and reports when the transmitter has gone idle again.
module uart_byte_sender (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       send,
  input  logic       hold,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  output logic       hold_done
);

  logic waited;

  // waited is low in the first wait cycle so the transmitter has time to raise tx_busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_data <= 8'h00;
      waited  <= 1'b0;
    end else begin
      if (load) begin
        tx_data <= load_byte;
      end
      waited <= hold;
    end
  end

  assign tx_wr_en  = send & ~tx_busy;
  assign hold_done = waited & ~tx_busy;

endmodule

// File: rtl/sensor_responder.sv
// Answers UART sensor requests with two-byte payload/checksum frames.
// Define SENSOR_RESPONDER_ALARM_EN to enable repeating alarm frames and the 8'h00 silence code.
module sensor_responder
  import sm_proto_pkg::*;
#(
  parameter logic [7:0] CHK_KEY      = DEF_CHK_KEY,
  parameter int         ALARM_PERIOD = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] sensor_data,
  input  logic        alarm_in,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  output logic        busy,
  output logic        alarm_active,
  output logic        overrun
);

  state_t     state, state_nxt;
  logic       pend_valid;
  logic [7:0] pend_code;
  logic [7:0] chk_byte;
  logic [7:0] payload;
  logic       rx_req;
  logic       pend_clear;
  logic       gap_reload;
  logic       alarm_due;
  logic       snd_load;
  logic [7:0] snd_byte;
  logic       snd_send;
  logic       snd_hold;
  logic       snd_done;

  assign rx_req  = rx_valid && (rx_data != ALARM_CODE);
  assign payload = pend_valid ? request_payload(pend_code, sensor_data) : ALARM_CODE;
  assign busy    = (state != ST_IDLE);

  // A request landing in the LOAD cycle replaces the one being consumed, so it is not an overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_code  <= 8'h00;
      overrun    <= 1'b0;
    end else if (rx_req) begin
      pend_valid <= 1'b1;
      pend_code  <= rx_data;
      if (pend_valid && !pend_clear) begin
        overrun <= 1'b1;
      end
    end else if (pend_clear) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_byte <= 8'h00;
    end else if (state == ST_LOAD) begin
      chk_byte <= payload ^ CHK_KEY;
    end
  end

`ifdef SENSOR_RESPONDER_ALARM_EN
  localparam int GAP_W = (ALARM_PERIOD < 2) ? 1 : $clog2(ALARM_PERIOD + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             alarm_prev;

  // Only a fresh rising edge arms the alarm; a level still held after silence stays quiet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarm_prev   <= 1'b0;
      alarm_active <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      alarm_prev <= alarm_in;
      if (alarm_in && !alarm_prev) begin
        alarm_active <= 1'b1;
        gap_cnt      <= '0;
      end else begin
        if (rx_valid && (rx_data == ALARM_CODE)) begin
          alarm_active <= 1'b0;
        end
        if (gap_reload) begin
          gap_cnt <= GAP_W'(ALARM_PERIOD);
        end else if (alarm_active && (gap_cnt != '0)) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
      end
    end
  end

  assign alarm_due = alarm_active && (gap_cnt == '0);
`else
  logic unused_alarm;
  assign unused_alarm = alarm_in ^ gap_reload;
  assign alarm_active = 1'b0;
  assign alarm_due    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending requests win over a due alarm frame; LOAD falls back to the alarm code when nothing is pending.
  always_comb begin
    state_nxt  = state;
    snd_load   = 1'b0;
    snd_byte   = chk_byte;
    snd_send   = 1'b0;
    snd_hold   = 1'b0;
    pend_clear = 1'b0;
    gap_reload = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid || alarm_due) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        snd_load   = 1'b1;
        snd_byte   = payload;
        pend_clear = 1'b1;
        state_nxt  = ST_SEND_P;
      end
      ST_SEND_P: begin
        snd_send = 1'b1;
        if (!tx_busy) begin
          state_nxt = ST_WAIT_P;
        end
      end
      ST_WAIT_P: begin
        snd_hold = 1'b1;
        if (snd_done) begin
          snd_load  = 1'b1;
          state_nxt = ST_SEND_C;
        end
      end
      ST_SEND_C: begin
        snd_send = 1'b1;
        if (!tx_busy) begin
          state_nxt = ST_WAIT_C;
        end
      end
      ST_WAIT_C: begin
        snd_hold = 1'b1;
        if (snd_done) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_reload = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  uart_byte_sender u_sender (
    .clock     (clock),
    .reset     (reset),
    .load      (snd_load),
    .load_byte (snd_byte),
    .send      (snd_send),
    .hold      (snd_hold),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .hold_done (snd_done)
  );

endmodule

// File: tb/tb_sensor_responder.sv
// Self-checking bench for sensor_responder: a UART transmitter model captures frames
// and each scenario compares them with frames derived from the request rules.
`timescale 1ns/1ps
module tb_sensor_responder;

  localparam logic [7:0] KEY    = 8'h37;
  localparam int         PERIOD = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] sensor_data = 32'h0;
  logic        alarm_in = 1'b0;
  logic        uart_busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        busy;
  logic        alarm_active;
  logic        overrun;

  logic [7:0]  captured[$];
  int          checks = 0;
  int          failures = 0;

  assign tx_busy = uart_busy | hold_busy;

  always #5 clock = ~clock;

  sensor_responder #(
    .CHK_KEY      (KEY),
    .ALARM_PERIOD (PERIOD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .sensor_data  (sensor_data),
    .alarm_in     (alarm_in),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_wr_en     (tx_wr_en),
    .busy         (busy),
    .alarm_active (alarm_active),
    .overrun      (overrun)
  );

  // UART transmitter: takes a byte on each strobe, then stays busy for a few cycles.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_wr_en === 1'b1) begin
        captured.push_back(tx_data);
        @(posedge clock);
        #1 uart_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1 uart_busy = 1'b0;
      end
    end
  end

  function automatic logic [7:0] model_payload(input logic [7:0] code, input logic [31:0] sensors);
    int         idx;
    logic [7:0] v;
    if (code >= 8'd1 && code <= 8'd4) begin
      idx = int'(code) - 1;
      v = 8'((sensors >> (8 * idx)) & 32'hFF);
      return (v == 8'h00) ? 8'h01 : v;
    end
    return 8'hFF;
  endfunction

  task automatic pulse_rx(input logic [7:0] code);
    @(posedge clock);
    #1 rx_data = code;
    rx_valid = 1'b1;
    @(posedge clock);
    #1 rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_bytes(input int n, input bit need_idle, input string what);
    int cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!(captured.size() >= n && (!need_idle || busy === 1'b0)) && cyc < 3000);
    if (!(captured.size() >= n && (!need_idle || busy === 1'b0))) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: bytes=%0d required=%0d busy=%b", what, captured.size(), n, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (tx_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%b exp=0", tx_wr_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (alarm_active !== 1'b0) begin failures++; $display("[TB] FAIL reset_alarm got=%b exp=0", alarm_active); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || tx_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle busy=%b wr_en=%b exp=0,0", busy, tx_wr_en); end
  endtask

  task automatic test_latency();
    captured.delete();
    sensor_data = 32'h0000_5A00;
    pulse_rx(8'h02);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k < 3) begin
        checks++; if (tx_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL latency_early cycle=%0d wr_en=%b exp=0", k, tx_wr_en); end
      end else begin
        checks++; if (tx_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL latency_strobe wr_en=%b exp=1", tx_wr_en); end
        checks++; if (tx_data !== 8'h5A) begin failures++; $display("[TB] FAIL latency_data got=%h exp=5a", tx_data); end
      end
    end
    wait_bytes(2, 1'b1, "latency_frame");
    repeat (10) @(negedge clock);
    checks++; if (captured.size() !== 2) begin failures++; $display("[TB] FAIL latency_count got=%0d exp=2", captured.size()); end
    checks++; if (captured.size() >= 2 && captured[1] !== 8'h6D) begin failures++; $display("[TB] FAIL latency_chk got=%h exp=6d", captured[1]); end
  endtask

  task automatic test_fixed_vectors();
    logic [7:0]  codes[2]   = '{8'h01, 8'h09};
    logic [31:0] sensors[2] = '{32'h1122_3300, 32'hDEAD_BEEF};
    logic [7:0]  exp_p[2]   = '{8'h01, 8'hFF};
    logic [7:0]  exp_c[2]   = '{8'h36, 8'hC8};
    for (int i = 0; i < 2; i++) begin
      captured.delete();
      sensor_data = sensors[i];
      pulse_rx(codes[i]);
      wait_bytes(2, 1'b1, "fixed_frame");
      checks++;
      if (captured.size() !== 2 || captured[0] !== exp_p[i] || captured[1] !== exp_c[i]) begin
        failures++;
        $display("[TB] FAIL fixed_frame code=%h got=%p exp=%h,%h", codes[i], captured, exp_p[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_random_requests();
    logic [7:0]  code;
    logic [31:0] sensors;
    logic [7:0]  p;
    int          sel;
    int          ch;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 5);
      sensors = $urandom;
      if (sel <= 3) begin
        code = 8'(sel + 1);
      end else if (sel == 4) begin
        code = 8'($urandom_range(5, 255));
      end else begin
        ch = $urandom_range(0, 3);
        code = 8'(ch + 1);
        sensors[ch*8 +: 8] = 8'h00;
      end
      p = model_payload(code, sensors);
      captured.delete();
      sensor_data = sensors;
      pulse_rx(code);
      wait_bytes(2, 1'b1, "random_frame");
      checks++;
      if (captured.size() !== 2 || captured[0] !== p || captured[1] !== (p ^ KEY)) begin
        failures++;
        $display("[TB] FAIL random_frame code=%h sensors=%h got=%p exp=%h,%h", code, sensors, captured, p, p ^ KEY);
      end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL no_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    captured.delete();
    sensor_data = 32'h4433_2211;
    pulse_rx(8'h01);
    wait_bytes(1, 1'b0, "overrun_first_byte");
    pulse_rx(8'h02);
    pulse_rx(8'h03);
    wait_bytes(4, 1'b1, "overrun_frames");
    repeat (20) @(negedge clock);
    checks++; if (captured.size() !== 4) begin failures++; $display("[TB] FAIL overrun_count got=%0d exp=4", captured.size()); end
    checks++;
    if (captured.size() >= 4 && (captured[0] !== 8'h11 || captured[1] !== 8'h26 ||
                                 captured[2] !== 8'h33 || captured[3] !== 8'h04)) begin
      failures++;
      $display("[TB] FAIL overrun_order got=%p exp=11,26,33,04", captured);
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_flag got=%b exp=1", overrun); end
  endtask

  task automatic test_busy_hold();
    int strobes = 0;
    captured.delete();
    sensor_data = 32'hA500_0000;
    hold_busy = 1'b1;
    pulse_rx(8'h04);
    repeat (50) begin
      @(negedge clock);
      if (tx_wr_en === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL hold_no_strobe got=%0d exp=0", strobes); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_busy_flag got=%b exp=1", busy); end
    @(posedge clock);
    #1 hold_busy = 1'b0;
    wait_bytes(2, 1'b1, "hold_frame");
    checks++;
    if (captured.size() !== 2 || captured[0] !== 8'hA5 || captured[1] !== 8'h92) begin
      failures++;
      $display("[TB] FAIL hold_frame got=%p exp=a5,92", captured);
    end
  endtask

  task automatic test_reset_midframe();
    captured.delete();
    sensor_data = 32'h0000_00C3;
    pulse_rx(8'h01);
    wait_bytes(1, 1'b0, "midframe_first_byte");
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++; if (tx_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL midreset_wr_en got=%b exp=0", tx_wr_en); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL midreset_tx_data got=%h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL midreset_overrun got=%b exp=0", overrun); end
    checks++; if (alarm_active !== 1'b0) begin failures++; $display("[TB] FAIL midreset_alarm got=%b exp=0", alarm_active); end
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (captured.size() !== 1) begin failures++; $display("[TB] FAIL midreset_no_resume got=%0d exp=1", captured.size()); end
    captured.delete();
    pulse_rx(8'h01);
    wait_bytes(2, 1'b1, "midreset_fresh_frame");
    checks++;
    if (captured.size() !== 2 || captured[0] !== 8'hC3 || captured[1] !== 8'hF4) begin
      failures++;
      $display("[TB] FAIL midreset_fresh_frame got=%p exp=c3,f4", captured);
    end
  endtask

`ifdef SENSOR_RESPONDER_ALARM_EN
  task automatic test_alarm();
    int gaps[$];
    int run = 0;
    int cyc = 0;
    int target;
    captured.delete();
    @(posedge clock);
    #1 alarm_in = 1'b1;
    while (captured.size() < 6 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (busy === 1'b0) begin
        run++;
      end else begin
        if (run > 0 && captured.size() >= 2) gaps.push_back(run);
        run = 0;
      end
    end
    checks++; if (captured.size() < 6) begin failures++; $display("[TB] FAIL alarm_frames got=%0d exp>=6", captured.size()); end
    for (int i = 0; i < captured.size(); i++) begin
      checks++;
      if (captured[i] !== ((i % 2 == 0) ? 8'h00 : 8'h37)) begin
        failures++;
        $display("[TB] FAIL alarm_byte idx=%0d got=%h exp=%h", i, captured[i], (i % 2 == 0) ? 8'h00 : 8'h37);
      end
    end
    checks++; if (gaps.size() < 1) begin failures++; $display("[TB] FAIL alarm_gap_seen got=%0d exp>=1", gaps.size()); end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] < PERIOD || gaps[i] > PERIOD + 1) begin
        failures++;
        $display("[TB] FAIL alarm_gap got=%0d exp=%0d..%0d", gaps[i], PERIOD, PERIOD + 1);
      end
    end
    checks++; if (alarm_active !== 1'b1) begin failures++; $display("[TB] FAIL alarm_active got=%b exp=1", alarm_active); end
    cyc = 0;
    while (captured.size() % 2 == 0 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    target = captured.size() + 1;
    pulse_rx(8'h00);
    wait_bytes(target, 1'b1, "silence_frame_end");
    repeat (60) @(negedge clock);
    checks++; if (captured.size() !== target) begin failures++; $display("[TB] FAIL silence_stop got=%0d exp=%0d", captured.size(), target); end
    checks++; if (alarm_active !== 1'b0) begin failures++; $display("[TB] FAIL silence_alarm got=%b exp=0", alarm_active); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL silence_no_rearm busy=%b exp=0", busy); end
    alarm_in = 1'b0;
  endtask
`else
  task automatic test_alarm();
    captured.delete();
    @(posedge clock);
    #1 alarm_in = 1'b1;
    pulse_rx(8'h00);
    repeat (40) @(negedge clock);
    checks++; if (captured.size() !== 0) begin failures++; $display("[TB] FAIL alarm_off_frames got=%0d exp=0", captured.size()); end
    checks++; if (alarm_active !== 1'b0) begin failures++; $display("[TB] FAIL alarm_off_active got=%b exp=0", alarm_active); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL alarm_off_busy got=%b exp=0", busy); end
    alarm_in = 1'b0;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_fixed_vectors();
    test_random_requests();
    test_alarm();
    test_busy_hold();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_responder.md
SENSOR_RESPONDER -- requirements
Module: sensor_responder

Interface
REQ-001 Parameter CHK_KEY, default 8'h37, XOR key for checksum byte.
REQ-002 Parameter ALARM_PERIOD, default 255, idle cycles between repeated alarm frames.
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle pulse, rx_data valid.
REQ-007 sensor_data  input  32  four 8-bit sensor channels; ch0 = [7:0].
REQ-008 alarm_in  input  1  level alarm request from sensor logic.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 tx_data  output  8  byte to UART transmitter.
REQ-011 tx_wr_en  output  1  one-cycle write strobe to UART transmitter.
REQ-012 busy  output  1  frame in progress (any state other than IDLE).
REQ-013 alarm_active  output  1  alarm latched, frames repeating.
REQ-014 overrun  output  1  sticky: a pending request was overwritten.

Function
REQ-015 Frame SHALL be two bytes: payload P, then P ^ CHK_KEY.
REQ-016 Request codes 8'h01..8'h04 SHALL select sensor channel 0..3; payload = channel value, captured when leaving IDLE.
REQ-017 Channel value 8'h00 SHALL be sent as 8'h01 (8'h00 is reserved for alarm).
REQ-018 Any other nonzero request code SHALL be answered with payload 8'hFF.
REQ-019 Received 8'h00 SHALL clear alarm_active (silence) and generate no frame.
REQ-020 One-deep pending register: rx_valid with a nonzero code in any state latches the code; if pending is already full, it is overwritten and overrun set.
REQ-021 States: IDLE, LOAD, SEND_P, WAIT_P, SEND_C, WAIT_C, GAP.
REQ-022 IDLE: pending request -> LOAD; else alarm_active and gap counter expired -> LOAD with payload 8'h00; else stay.
REQ-023 Request SHALL take priority over alarm frame when both are ready in the same cycle.
REQ-024 LOAD: compute payload and checksum, clear pending, -> SEND_P.
REQ-025 SEND_P/SEND_C: when tx_busy==0, drive tx_data and pulse tx_wr_en for exactly one cycle, -> WAIT_P/WAIT_C; else hold.
REQ-026 WAIT_x: wait one cycle minimum, then until tx_busy==0; WAIT_P -> SEND_C, WAIT_C -> GAP.
REQ-027 GAP: one cycle, reload alarm gap counter with ALARM_PERIOD, -> IDLE.
REQ-028 Latency: rx_valid in IDLE with tx_busy==0 SHALL give first tx_wr_en exactly 3 cycles later.
REQ-029 Rising edge of alarm_in SHALL set alarm_active and force gap counter to 0; a held level SHALL not re-arm after silence.
REQ-030 Silence received mid-alarm-frame SHALL let the current frame finish; no further alarm frames.
REQ-031 Gap counter SHALL decrement saturating at 0, only while alarm_active.

Reset
REQ-032 Reset asserted: state IDLE, tx_data 8'h00, tx_wr_en 0, busy 0, alarm_active 0, overrun 0, pending empty, gap counter 0, alarm_in edge detector 0.
REQ-033 Reset mid-frame SHALL drop tx_wr_en the same instant; no partial frame resumes.

Configuration
REQ-034 Macro SENSOR_RESPONDER_ALARM_EN defined: alarm behaviour per REQ-019, REQ-022, REQ-029..031.
REQ-035 Macro undefined: alarm_in ignored, alarm_active tied 0, 8'h00 request ignored, gap counter absent.

Structure
REQ-036 Package sm_proto_pkg SHALL hold CHK_KEY default, request codes, alarm/silence code 8'h00, error payload 8'hFF, state enum.
REQ-037 Sub-module uart_byte_sender SHALL implement the SEND/WAIT tx_busy handshake for one byte; instantiated once, sequenced by the FSM.

Verification
REQ-038 rx 8'h02, sensor_data 32'h0000_5A00 -> tx 8'h5A then 8'h6D, one wr_en each.
REQ-039 rx 8'h01 with ch0 = 8'h00 -> tx 8'h01, 8'h36; rx 8'h09 -> tx 8'hFF, 8'hC8.
REQ-040 alarm_in rises, ALARM_PERIOD=10 -> frames 8'h00,8'h37 repeating with GAP of 10 idle cycles; rx 8'h00 -> current frame completes, no more.
REQ-041 Three requests (01,02,03) during one frame -> served 01 then 03; overrun=1.
REQ-042 tx_busy held high 50 cycles at SEND_P -> no wr_en until release; then normal frame.
REQ-043 reset pulsed low during WAIT_P -> tx_wr_en 0, all outputs at reset values, next request yields full fresh frame.
